riscv_operand_fetch: RTL
========================

// Module: riscv_operand_fetch
// PURPOSE
//  Requester side of the 2R1W register file: takes decoded rs1/rs2 from decode, drives the
//  RF sync-read ports (data 1 clk after en), forwards writeback, returns bypassed operands.
//  Single-entry valid/ready pipeline stage between decode and execute; full throughput.
// PARAMETERS
//  DATA_WIDTH  32  operand / register width
//  ADDR_WIDTH  5   register index width (2**ADDR_WIDTH registers, index 0 = x0)
//  TAG_WIDTH   32  opaque payload carried with each request (PC, uop bits)
// PORTS
//  clk            in   1           clock, all state on posedge
//  rst            in   1           asynchronous, active-high reset
//  in_valid       in   1           decode request valid
//  in_ready       out  1           stage can accept
//  in_rs1/in_rs2  in   ADDR_WIDTH  source indices
//  in_rs1_use/2   in   1           operand needed; 0 -> no RF read, operand = 0
//  in_tag         in   TAG_WIDTH   payload
//  out_valid      out  1           operands valid
//  out_ready      in   1           execute accepts
//  out_rs1_data/2 out  DATA_WIDTH  operand values
//  out_tag        out  TAG_WIDTH   payload of accepted request
//  wb_valid       in   1           writeback strobe
//  wb_addr        in   ADDR_WIDTH  writeback index
//  wb_data        in   DATA_WIDTH  writeback value
//  rf_rd1_addr/en out  ADDR_WIDTH/1  RF read port 1 request
//  rf_rd1_data    in   DATA_WIDTH  RF read port 1 data (valid 1 clk after en, holds while en=0)
//  rf_rd2_addr/en/data             same for port 2
//  rf_wr_addr/en/data out          RF write port
// BEHAVIOUR
//  - Reset: out_valid=0, out_tag=0, out_rsN_data=0, hold regs/flags=0; in_ready=1 after reset.
//  - in_ready = !out_valid | out_ready (comb). Accept = in_valid & in_ready.
//  - On accept: rf_rdN_en=1 iff in_rsN_use & in_rsN!=0, rf_rdN_addr=in_rsN (same cycle, comb).
//    rf_rdN_en=0 in every other cycle, so RF read regs hold while stalled.
//  - Next posedge: out_valid=1, tag/addr/use latched; latency accept->out_valid = 1 clk.
//  - out_valid & out_ready & !accept -> out_valid=0 next clk; with accept -> stays 1 (back-to-back).
//  - Per operand hold: hv flag + hd reg. Set at accept if wb_valid & wb_addr==in_rsN (RF returns
//    the pre-write value for same-cycle write/read). While out_valid & !out_ready, any matching
//    wb sets hv, hd=wb_data (latest wins). Cleared on next accept unless re-set.
//  - out_rsN_data = !out_valid | !use | addr==0 ? 0 : hv ? hd : rf_rdN_data.
//  - Operand = register value including every wb up to the cycle before handoff.
//  - Write-through: rf_wr_addr=wb_addr, rf_wr_data=wb_data, rf_wr_en=wb_valid & wb_addr!=0
//    (x0 writes dropped; x0 reads 0).
//  - rs1==rs2 legal: both ports read, both bypass independently.
//  - Reset mid-operation: held request discarded, out_valid drops asynchronously.
// CONFIGURATION
//  RISCV_OPF_PERF_EN defined: adds output perf_stall_cnt [31:0], +1 each clk with
//  out_valid & !out_ready, wraps at 2**32, reset 0. Undefined: port and counter absent.
// STRUCTURE
//  riscv_pkg: DATA_WIDTH/ADDR_WIDTH defaults, REG_ZERO index constant, operand-slice struct
//  (addr, use, hv, hd). Sub-module riscv_opf_operand: one hold/bypass/select slice,
//  instantiated twice; top holds handshake, tag reg, RF port drive, perf counter.
// TESTING (RF model with 1-clk read latency attached)
//  1 wb x5=0x1234; next clk accept rs1=5 -> 1 clk later out_valid=1, out_rs1_data=0x1234.
//  2 wb x7=0xAAAA in same clk as accept rs1=7,rs2=7 -> out_rs1_data=out_rs2_data=0xAAAA.
//  3 x3=1; accept rs2=3, out_ready=0 for 3 clk, wb x3=2 then x3=3 in stall -> in_ready=0,
//    rf_rd2_en=0 in stall, handoff out_rs2_data=3; PERF_EN: perf_stall_cnt=3.
//  4 wb x0=0xFFFF -> rf_wr_en=0; accept rs1=0, rs2_use=0 -> rf_rd1_en=0, both operands 0.
//  5 4 requests tags 1..4 back-to-back, out_ready=1 -> out_valid 4 consecutive clk, tags 1..4.
//  6 rst pulse while out_valid=1 & out_ready=0 -> out_valid=0 at once, no handoff, counter 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the operand-fetch stage.
//   RV_DATA_WIDTH / RV_ADDR_WIDTH / RV_TAG_WIDTH : default widths
//   REG_ZERO                                    : index of the hard-wired zero register
//   opf_slice_t                                 : per-operand state at default widths
//                                                 (register index, use bit, hold flag, hold data)
package riscv_pkg;
  localparam int RV_DATA_WIDTH = 32;
  localparam int RV_ADDR_WIDTH = 5;
  localparam int RV_TAG_WIDTH  = 32;
  localparam int REG_ZERO      = 0;

  typedef struct packed {
    logic [RV_ADDR_WIDTH-1:0] addr;
    logic                     used;
    logic                     hv;
    logic [RV_DATA_WIDTH-1:0] hd;
  } opf_slice_t;

  // True when a writeback targets the given register index.
  function automatic logic wb_hit(input logic wb_valid,
                                  input logic [RV_ADDR_WIDTH-1:0] wb_addr,
                                  input logic [RV_ADDR_WIDTH-1:0] addr);
    return wb_valid && (wb_addr == addr);
  endfunction
endpackage

// File: rtl/riscv_opf_operand.sv
// riscv_opf_operand: one operand slice of the operand-fetch stage.
//   Latches the register index / use bit at accept, tracks writebacks that the
//   RF read data cannot reflect (same-cycle write at accept, writes during a
//   stall) in a hold flag + hold register, and selects the final operand.
// Ports:
//   clk, rst          clock, async active-high reset
//   accept            request accepted this cycle
//   stall             out_valid & !out_ready
//   out_valid         stage holds a valid request
//   in_addr, in_use   source index / operand-needed bit from decode
//   wb_valid/addr/data writeback bus
//   rf_rd_data        RF sync-read data (valid 1 clk after rd_en, then held)
//   rd_en             RF read enable for this operand
//   op_data           selected operand value
module riscv_opf_operand
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = RV_DATA_WIDTH,
  parameter int ADDR_WIDTH = RV_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,
  input  logic                  stall,
  input  logic                  out_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_use,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] op_data
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  used;
    logic                  hv;
    logic [DATA_WIDTH-1:0] hd;
  } slice_t;

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  slice_t slice_q, slice_d;

  // x0 and unused operands never touch the RF.
  assign rd_en = accept && in_use && (in_addr != ZERO_IDX);

  always_comb begin
    slice_d = slice_q;
    if (accept) begin
      slice_d.addr = in_addr;
      slice_d.used = in_use;
      // RF returns the pre-write value for a same-cycle write, so capture it here.
      slice_d.hv   = wb_valid && (wb_addr == in_addr);
      if (wb_valid && (wb_addr == in_addr))
        slice_d.hd = wb_data;
    end else if (stall && wb_valid && (wb_addr == slice_q.addr)) begin
      // RF read regs are frozen while stalled; latest matching write wins.
      slice_d.hv = 1'b1;
      slice_d.hd = wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) slice_q <= '0;
    else     slice_q <= slice_d;
  end

  always_comb begin
    op_data = '0;
    if (out_valid && slice_q.used && (slice_q.addr != ZERO_IDX))
      op_data = slice_q.hv ? slice_q.hd : rf_rd_data;
  end
endmodule

// File: rtl/riscv_operand_fetch.sv
// riscv_operand_fetch: single-entry valid/ready stage between decode and execute.
//   Drives the 2R1W register file read ports at accept, writes back through the
//   RF write port, and returns operands bypassed with any writeback the RF read
//   data missed. Full throughput: accept and handoff may happen in one cycle.
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_valid/in_ready                decode handshake
//   in_rs1/in_rs2, in_rsN_use, in_tag request fields
//   out_valid/out_ready              execute handshake
//   out_rs1_data/out_rs2_data/out_tag operands and payload
//   wb_valid/wb_addr/wb_data         writeback bus
//   rf_rdN_addr/en/data              RF read ports (data 1 clk after en)
//   rf_wr_addr/en/data               RF write port
//   perf_stall_cnt                   stall-cycle counter, only with RISCV_OPF_PERF_EN
// Configuration macro: RISCV_OPF_PERF_EN
module riscv_operand_fetch
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = RV_DATA_WIDTH,
  parameter int ADDR_WIDTH = RV_ADDR_WIDTH,
  parameter int TAG_WIDTH  = RV_TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic                  in_rs1_use,
  input  logic                  in_rs2_use,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rs1_data,
  output logic [DATA_WIDTH-1:0] out_rs2_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] rf_rd1_addr,
  output logic                  rf_rd1_en,
  input  logic [DATA_WIDTH-1:0] rf_rd1_data,
  output logic [ADDR_WIDTH-1:0] rf_rd2_addr,
  output logic                  rf_rd2_en,
  input  logic [DATA_WIDTH-1:0] rf_rd2_data,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic                  rf_wr_en,
  output logic [DATA_WIDTH-1:0] rf_wr_data
`ifdef RISCV_OPF_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt
`endif
);
  logic                 out_valid_q, out_valid_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 accept, stall;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign stall    = out_valid_q && !out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    tag_d       = tag_q;
    if (accept) begin
      out_valid_d = 1'b1;
      tag_d       = in_tag;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      tag_q       <= tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tag   = tag_q;

  // Read addresses follow decode directly; only the enables are qualified.
  assign rf_rd1_addr = in_rs1;
  assign rf_rd2_addr = in_rs2;

  assign rf_wr_addr = wb_addr;
  assign rf_wr_data = wb_data;
  assign rf_wr_en   = wb_valid && (wb_addr != ADDR_WIDTH'(REG_ZERO));

  riscv_opf_operand #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_op1 (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .stall     (stall),
    .out_valid (out_valid_q),
    .in_addr   (in_rs1),
    .in_use    (in_rs1_use),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rf_rd_data(rf_rd1_data),
    .rd_en     (rf_rd1_en),
    .op_data   (out_rs1_data)
  );

  riscv_opf_operand #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_op2 (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .stall     (stall),
    .out_valid (out_valid_q),
    .in_addr   (in_rs2),
    .in_use    (in_rs2_use),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rf_rd_data(rf_rd2_data),
    .rd_en     (rf_rd2_en),
    .op_data   (out_rs2_data)
  );

`ifdef RISCV_OPF_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;  // wraps naturally
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule
